ldd_activity_sched: RTL and testbench

Sequencer and activity monitor for the `ldd` 9-input/19-output combinational decoder in the power-aware synthesis bench flow. It accepts input vectors from a single requester over a valid/ready handshake and drives them onto the decoder one at a time. After a programmable settle time it samples the decoder outputs and accumulates the output switching activity (Hamming distance between consecutive samples). Results are reported per window of WIN vectors over a second valid/ready handshake, for toggle-based power estimation.

---
 rtl/ldd_sched_pkg.sv | 14 +
 rtl/ldd_activity_sched_if.sv | 25 ++
 rtl/ldd_popcount19.sv | 14 +
 rtl/ldd_activity_sched.sv | 109 ++++++++++
 tb/tb_ldd_activity_sched.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ldd_sched_pkg.sv
// Shared types and widths for the ldd activity sequencer.
// The decoder has 9 inputs and 19 outputs; a 19-bit Hamming distance fits in 5 bits.
package ldd_sched_pkg;
    localparam int LDD_IN_W  = 9;
    localparam int LDD_OUT_W = 19;
    localparam int HD_W      = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        REPORT
    } state_t;
endpackage

// File: rtl/ldd_activity_sched_if.sv
// Vector request channel and window result channel of the activity sequencer.
// The master drives vectors in and takes results out; the slave is the sequencer.
interface ldd_activity_sched_if #(
    parameter int CNT_W = 16
);
    import ldd_sched_pkg::*;

    logic                vec_valid;
    logic                vec_ready;
    logic [LDD_IN_W-1:0] vec_data;
    logic                res_valid;
    logic                res_ready;
    logic [CNT_W-1:0]    res_toggles;
    logic [HD_W-1:0]     res_max;

    modport master (
        output vec_valid, vec_data, res_ready,
        input  vec_ready, res_valid, res_toggles, res_max
    );

    modport slave (
        input  vec_valid, vec_data, res_ready,
        output vec_ready, res_valid, res_toggles, res_max
    );
endinterface

// File: rtl/ldd_popcount19.sv
// Population count of a 19-bit word; used as the Hamming distance of two samples.
module ldd_popcount19
    import ldd_sched_pkg::*;
(
    input  logic [LDD_OUT_W-1:0] din,
    output logic [HD_W-1:0]      cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < LDD_OUT_W; i++) begin
            cnt = cnt + HD_W'(din[i]);
        end
    end
endmodule

// File: rtl/ldd_activity_sched.sv
// Drives vectors onto the ldd decoder, samples its outputs after a settle time and
// reports saturating output-toggle totals and the peak per-vector distance per window.
module ldd_activity_sched
    import ldd_sched_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int WIN        = 16,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    ldd_activity_sched_if.slave  bus,
    output logic [LDD_IN_W-1:0]  ldd_in,
    input  logic [LDD_OUT_W-1:0] ldd_out
);
    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int VCNT_W = $clog2(WIN + 1);

    state_t               state;
    logic [SCNT_W-1:0]    scnt;
    logic [VCNT_W-1:0]    vcnt;
    logic [LDD_OUT_W-1:0] prev_out;
    logic                 first;
    logic [CNT_W-1:0]     acc;
    logic [HD_W-1:0]      max_hd;
    logic                 res_valid;
    logic [HD_W-1:0]      hd_raw;
    logic [HD_W-1:0]      hd;
    logic [CNT_W:0]       sum;
    logic [CNT_W-1:0]     acc_nxt;

    ldd_popcount19 u_pop (
        .din (ldd_out ^ prev_out),
        .cnt (hd_raw)
    );

    // The very first sample after reset/clear has no valid predecessor.
    always_comb begin
        hd      = first ? '0 : hd_raw;
        sum     = {1'b0, acc} + (CNT_W+1)'(hd);
        acc_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    assign bus.vec_ready   = (state == IDLE) && !clr;
    assign bus.res_valid   = res_valid;
    assign bus.res_toggles = acc;
    assign bus.res_max     = max_hd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            scnt      <= '0;
            vcnt      <= '0;
            prev_out  <= '0;
            first     <= 1'b1;
            acc       <= '0;
            max_hd    <= '0;
            res_valid <= 1'b0;
            ldd_in    <= '0;
        end else if (clr) begin
            // prev_out is kept; first masks it for the next sample anyway.
            state     <= IDLE;
            vcnt      <= '0;
            first     <= 1'b1;
            acc       <= '0;
            max_hd    <= '0;
            res_valid <= 1'b0;
            ldd_in    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.vec_valid) begin
                        ldd_in <= bus.vec_data;
                        scnt   <= SCNT_W'(SETTLE_CYC - 1);
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (scnt == '0) state <= SAMPLE;
                    else            scnt  <= scnt - 1'b1;
                end
                SAMPLE: begin
                    acc      <= acc_nxt;
                    max_hd   <= (hd > max_hd) ? hd : max_hd;
                    prev_out <= ldd_out;
                    first    <= 1'b0;
                    vcnt     <= vcnt + 1'b1;
                    if (vcnt == VCNT_W'(WIN - 1)) begin
                        state     <= REPORT;
                        res_valid <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        acc       <= '0;
                        max_hd    <= '0;
                        vcnt      <= '0;
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldd_activity_sched.sv
// Directed bench: instance A (WIN=4, SETTLE_CYC=1, CNT_W=16) covers windows, backpressure,
// reset abort and clear; instance B (WIN=4, SETTLE_CYC=3, CNT_W=5) covers saturation and latency.
module tb_ldd_activity_sched;
    logic        clk;
    logic        rst_na, rst_nb;
    logic        clra, clrb;
    logic [8:0]  ldd_in_a, ldd_in_b;
    logic [18:0] ldd_out_a, ldd_out_b;

    int checks = 0;
    int passed = 0;

    ldd_activity_sched_if #(.CNT_W(16)) ifa ();
    ldd_activity_sched_if #(.CNT_W(5))  ifb ();

    ldd_activity_sched #(.SETTLE_CYC(1), .WIN(4), .CNT_W(16)) dut_a (
        .clk     (clk),
        .rst_n   (rst_na),
        .clr     (clra),
        .bus     (ifa),
        .ldd_in  (ldd_in_a),
        .ldd_out (ldd_out_a)
    );

    ldd_activity_sched #(.SETTLE_CYC(3), .WIN(4), .CNT_W(5)) dut_b (
        .clk     (clk),
        .rst_n   (rst_nb),
        .clr     (clrb),
        .bus     (ifb),
        .ldd_in  (ldd_in_b),
        .ldd_out (ldd_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  vin;
        logic [18:0] lout;
        bit          last;
        int          tog;
        int          mx;
        int          hold;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic logic rdy(input bit s);
        return s ? ifb.vec_ready : ifa.vec_ready;
    endfunction

    function automatic logic rv(input bit s);
        return s ? ifb.res_valid : ifa.res_valid;
    endfunction

    function automatic logic [31:0] rtog(input bit s);
        return s ? 32'(ifb.res_toggles) : 32'(ifa.res_toggles);
    endfunction

    function automatic logic [31:0] rmax(input bit s);
        return s ? 32'(ifb.res_max) : 32'(ifa.res_max);
    endfunction

    task automatic set_vv(input bit s, input logic v);
        if (s) ifb.vec_valid = v;
        else   ifa.vec_valid = v;
    endtask

    task automatic set_rr(input bit s, input logic v);
        if (s) ifb.res_ready = v;
        else   ifa.res_ready = v;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit s, input logic [8:0] v, input logic [18:0] o);
        int n = 0;
        while (!rdy(s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", rdy(s), 1);
        if (s) begin
            ifb.vec_data = v;
            ldd_out_b    = o;
        end else begin
            ifa.vec_data = v;
            ldd_out_a    = o;
        end
        set_vv(s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_vv(s, 1'b0);
    endtask

    task automatic wait_res(input bit s, input string nm);
        int n = 0;
        while (!rv(s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_valid"}, rv(s), 1);
    endtask

    task automatic get_res(input bit s, input string nm, input int tog, input int mx, input int hold);
        wait_res(s, nm);
        for (int k = 0; k < hold; k++) begin
            set_vv(s, 1'b1);
            @(negedge clk);
            check({nm, "_bp_valid"}, rv(s), 1);
            check({nm, "_bp_tog"}, rtog(s), tog);
            check({nm, "_bp_max"}, rmax(s), mx);
            check({nm, "_bp_vec_ready"}, rdy(s), 0);
        end
        set_vv(s, 1'b0);
        check({nm, "_tog"}, rtog(s), tog);
        check({nm, "_max"}, rmax(s), mx);
        set_rr(s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_rr(s, 1'b0);
        check({nm, "_valid_drop"}, rv(s), 0);
    endtask

    initial begin
        ifa.vec_valid = 0; ifa.vec_data = '0; ifa.res_ready = 0;
        ifb.vec_valid = 0; ifb.vec_data = '0; ifb.res_ready = 0;
        ldd_out_a = '0; ldd_out_b = '0;
        clra = 0; clrb = 0;
        rst_na = 0; rst_nb = 0;

        tbl[0]  = '{9'h001, 19'h00000, 0,  0,  0,  0};
        tbl[1]  = '{9'h002, 19'h7FFFF, 0,  0,  0,  0};
        tbl[2]  = '{9'h003, 19'h7FFFF, 0,  0,  0,  0};
        tbl[3]  = '{9'h004, 19'h00001, 1, 37, 19, 10};
        tbl[4]  = '{9'h0F0, 19'h00000, 0,  0,  0,  0};
        tbl[5]  = '{9'h0F1, 19'h00000, 0,  0,  0,  0};
        tbl[6]  = '{9'h0F2, 19'h00000, 0,  0,  0,  0};
        tbl[7]  = '{9'h0F3, 19'h00000, 1,  1,  1,  0};
        tbl[8]  = '{9'h155, 19'h00F0F, 0,  0,  0,  0};
        tbl[9]  = '{9'h0AA, 19'h000F0, 0,  0,  0,  0};
        tbl[10] = '{9'h1FF, 19'h3FFFF, 0,  0,  0,  0};
        tbl[11] = '{9'h100, 19'h3FFFE, 1, 35, 14,  2};

        repeat (3) @(negedge clk);
        check("rst_vec_ready", ifa.vec_ready, 1);
        check("rst_res_valid", ifa.res_valid, 0);
        check("rst_res_tog", ifa.res_toggles, 0);
        check("rst_res_max", ifa.res_max, 0);
        check("rst_ldd_in", ldd_in_a, 0);
        rst_na = 1; rst_nb = 1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            send(0, tbl[i].vin, tbl[i].lout);
            if (tbl[i].last) get_res(0, $sformatf("win_row%0d", i), tbl[i].tog, tbl[i].mx, tbl[i].hold);
        end

        // Reset during SETTLE aborts the partial window (acc = 17 + 19 beforehand).
        send(0, 9'h011, 19'h00000);
        send(0, 9'h012, 19'h7FFFF);
        send(0, 9'h1AB, 19'h00000);
        check("abort_ldd_in_settle", ldd_in_a, 9'h1AB);
        #2 rst_na = 0;
        #1;
        check("abort_ldd_in", ldd_in_a, 0);
        check("abort_tog", ifa.res_toggles, 0);
        check("abort_max", ifa.res_max, 0);
        check("abort_res_valid", ifa.res_valid, 0);
        check("abort_vec_ready", ifa.vec_ready, 1);
        @(negedge clk);
        rst_na = 1;
        @(negedge clk);
        check("abort_ready_after", ifa.vec_ready, 1);
        for (int i = 0; i < 4; i++) send(0, 9'h020, 19'h00001);
        get_res(0, "post_rst", 0, 0, 0);

        // Clear after 2 of 4 vectors: partial window discarded, first hd masked.
        send(0, 9'h031, 19'h7FFFF);
        send(0, 9'h032, 19'h7FFFF);
        clra = 1;
        #1 check("clr_vec_ready", ifa.vec_ready, 0);
        @(posedge clk);
        #1;
        check("clr_ldd_in", ldd_in_a, 0);
        check("clr_tog", ifa.res_toggles, 0);
        @(negedge clk);
        clra = 0;
        repeat (3) @(negedge clk);
        check("clr_no_result", ifa.res_valid, 0);
        send(0, 9'h041, 19'h00000);
        send(0, 9'h042, 19'h00000);
        send(0, 9'h043, 19'h00001);
        send(0, 9'h044, 19'h00003);
        get_res(0, "post_clr", 2, 1, 0);

        // Clear while a result is pending drops it.
        send(0, 9'h051, 19'h00007);
        send(0, 9'h052, 19'h00007);
        send(0, 9'h053, 19'h00007);
        send(0, 9'h054, 19'h0000F);
        wait_res(0, "clr_pending");
        check("clr_pending_tog", ifa.res_toggles, 2);
        clra = 1;
        @(posedge clk);
        #1 check("clr_drop_valid", ifa.res_valid, 0);
        @(negedge clk);
        clra = 0;
        #1 check("clr_drop_ready", ifa.vec_ready, 1);
        for (int i = 0; i < 4; i++) send(0, 9'h060, 19'h00007);
        get_res(0, "post_clr2", 0, 0, 0);

        // Saturation: hd 0,19,19,19 sums to 57, clamps to 31 in 5 bits.
        send(1, 9'h001, 19'h00000);
        send(1, 9'h002, 19'h7FFFF);
        send(1, 9'h003, 19'h00000);
        send(1, 9'h004, 19'h7FFFF);
        get_res(1, "sat", 31, 19, 0);

        // Latency with SETTLE_CYC=3: the value present at E0+4 is captured.
        while (!ifb.vec_ready) @(negedge clk);
        ifb.vec_data = 9'h0A5;
        ldd_out_b    = 19'h7FFFF;
        ifb.vec_valid = 1;
        @(posedge clk);
        #1;
        check("lat_ldd_in_e0", ldd_in_b, 9'h0A5);
        ifb.vec_data = 9'h15A;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_ldd_in_hold%0d", k), ldd_in_b, 9'h0A5);
            if (k == 3) begin
                ldd_out_b     = 19'h7FFFE;
                ifb.vec_valid = 0;
            end
        end
        @(posedge clk);
        #1 ldd_out_b = 19'h00000;
        check("lat_ldd_in_e4", ldd_in_b, 9'h0A5);
        @(negedge clk);
        for (int i = 0; i < 3; i++) send(1, 9'h0B0, 19'h7FFFE);
        get_res(1, "lat", 1, 1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d, expected %0d", passed, checks);
        $fatal(1, "timeout");
    end
endmodule
